// File: rtl/uparc_hilo_mul_ctl.sv
// uparc_hilo_mul_ctl
//   Multiply sequencer and HI/LO register file that sits between the execute
//   stage and the integer multiplier. It accepts multiply and move-to-HI/LO
//   requests, issues a one-cycle start to the multiplier, waits for its ready
//   and writes the 2*WIDTH result (or the accumulated result) into HI/LO.
//   Zero-latency (tied-ready) and multi-cycle multipliers are both supported.
//
// Configuration macro:
//   UPARC_MADD_EN  defined   -> ops MADD/MADDU/MSUB accumulate into {HI,LO}
//                  undefined -> those ops are accepted as NOPs, no adder built
//
// Ports:
//   clk_i          clock, all state on rising edge
//   nrst_i         synchronous active-low reset
//   req_valid_i    request present from execute stage
//   req_ready_o    ~busy; request accepted on req_valid_i & req_ready_o
//   req_op_i       000 NOP 001 MULT 010 MULTU 011 MTHI 100 MTLO
//                  101 MADD 110 MADDU 111 MSUB
//   req_rs_i       operand A / MTHI, MTLO data
//   req_rt_i       operand B
//   flush_i        cancels in-flight multiply, drops an offered request
//   busy_o         multiply in flight, HI/LO not yet valid
//   hi_o, lo_o     architectural HI/LO
//   mul_start_o    one-cycle start pulse to the multiplier
//   mul_signd_o    signed multiply select
//   mul_a_o/b_o    operands, stable from ISSUE until capture
//   mul_ready_i    multiplier result valid
//   mul_product_i  multiplier result
module uparc_hilo_mul_ctl #(
    parameter int WIDTH = 32
) (
    input  logic               clk_i,
    input  logic               nrst_i,
    input  logic               req_valid_i,
    output logic               req_ready_o,
    input  logic [2:0]         req_op_i,
    input  logic [WIDTH-1:0]   req_rs_i,
    input  logic [WIDTH-1:0]   req_rt_i,
    input  logic               flush_i,
    output logic               busy_o,
    output logic [WIDTH-1:0]   hi_o,
    output logic [WIDTH-1:0]   lo_o,
    output logic               mul_start_o,
    output logic               mul_signd_o,
    output logic [WIDTH-1:0]   mul_a_o,
    output logic [WIDTH-1:0]   mul_b_o,
    input  logic               mul_ready_i,
    input  logic [2*WIDTH-1:0] mul_product_i
);

    localparam logic [2:0] OP_MULT  = 3'b001;
    localparam logic [2:0] OP_MULTU = 3'b010;
    localparam logic [2:0] OP_MTHI  = 3'b011;
    localparam logic [2:0] OP_MTLO  = 3'b100;
`ifdef UPARC_MADD_EN
    localparam logic [2:0] OP_MADD  = 3'b101;
    localparam logic [2:0] OP_MADDU = 3'b110;
    localparam logic [2:0] OP_MSUB  = 3'b111;

    // How the captured product is folded into {HI,LO}
    typedef enum logic [1:0] {ACC_SET, ACC_ADD, ACC_SUB} acc_e;
    acc_e acc_q, acc_d;
`endif

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_e;

    state_e               state_q;
    logic [WIDTH-1:0]     hi_q, lo_q, a_q, b_q;
    logic                 busy_q, start_q, signd_q;
    logic                 is_mul_d, signd_d;
    logic [2*WIDTH-1:0]   hilo_d;

    // Request decode: which ops start the multiplier and which are signed.
    always_comb begin
        is_mul_d = 1'b0;
        signd_d  = 1'b0;
`ifdef UPARC_MADD_EN
        acc_d    = ACC_SET;
`endif
        case (req_op_i)
            OP_MULT:  begin is_mul_d = 1'b1; signd_d = 1'b1; end
            OP_MULTU: begin is_mul_d = 1'b1; end
`ifdef UPARC_MADD_EN
            OP_MADD:  begin is_mul_d = 1'b1; signd_d = 1'b1; acc_d = ACC_ADD; end
            OP_MADDU: begin is_mul_d = 1'b1; acc_d = ACC_ADD; end
            OP_MSUB:  begin is_mul_d = 1'b1; signd_d = 1'b1; acc_d = ACC_SUB; end
`endif
            default:  ;
        endcase
    end

    // Value written to {HI,LO} at capture; accumulate wraps mod 2^(2*WIDTH).
    always_comb begin
        hilo_d = mul_product_i;
`ifdef UPARC_MADD_EN
        case (acc_q)
            ACC_ADD: hilo_d = {hi_q, lo_q} + mul_product_i;
            ACC_SUB: hilo_d = {hi_q, lo_q} - mul_product_i;
            default: hilo_d = mul_product_i;
        endcase
`endif
    end

    always_ff @(posedge clk_i) begin
        if (!nrst_i) begin
            state_q <= S_IDLE;
            hi_q    <= '0;
            lo_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            busy_q  <= 1'b0;
            start_q <= 1'b0;
            signd_q <= 1'b0;
`ifdef UPARC_MADD_EN
            acc_q   <= ACC_SET;
`endif
        end else begin
            start_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    // busy_q is 0 here, so req_ready_o is implicitly 1
                    if (req_valid_i && !flush_i) begin
                        if (is_mul_d) begin
                            a_q     <= req_rs_i;
                            b_q     <= req_rt_i;
                            signd_q <= signd_d;
`ifdef UPARC_MADD_EN
                            acc_q   <= acc_d;
`endif
                            start_q <= 1'b1;
                            busy_q  <= 1'b1;
                            state_q <= S_ISSUE;
                        end else if (req_op_i == OP_MTHI) begin
                            hi_q <= req_rs_i;
                        end else if (req_op_i == OP_MTLO) begin
                            lo_q <= req_rs_i;
                        end
                    end
                end
                S_ISSUE: begin
                    // No capture here: the multiplier only sees start this cycle
                    if (flush_i) begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else begin
                        state_q <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    // Flush wins over a simultaneous ready: product dropped
                    if (flush_i) begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else if (mul_ready_i) begin
                        {hi_q, lo_q} <= hilo_d;
                        busy_q       <= 1'b0;
                        state_q      <= S_IDLE;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign req_ready_o = ~busy_q;
    assign busy_o      = busy_q;
    assign hi_o        = hi_q;
    assign lo_o        = lo_q;
    assign mul_start_o = start_q;
    assign mul_signd_o = signd_q;
    assign mul_a_o     = a_q;
    assign mul_b_o     = b_q;

endmodule

// File: tb/tb_uparc_hilo_mul_ctl.sv
module tb_uparc_hilo_mul_ctl;
  localparam int W = 32;

  logic           clk, nrst, req_valid, req_ready, flush, busy;
  logic [2:0]     req_op;
  logic [W-1:0]   req_rs, req_rt, hi, lo, mul_a, mul_b;
  logic           mul_start, mul_signd, mul_ready, rdy_en;
  logic [2*W-1:0] mul_product;

  int total = 0;
  int bad   = 0;

  uparc_hilo_mul_ctl #(.WIDTH(W)) dut (
    .clk_i(clk), .nrst_i(nrst), .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_op_i(req_op), .req_rs_i(req_rs), .req_rt_i(req_rt), .flush_i(flush),
    .busy_o(busy), .hi_o(hi), .lo_o(lo), .mul_start_o(mul_start),
    .mul_signd_o(mul_signd), .mul_a_o(mul_a), .mul_b_o(mul_b),
    .mul_ready_i(mul_ready), .mul_product_i(mul_product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // zero-latency multiplier model; ready gated by the bench
  logic signed [2*W-1:0] sa, sb;
  always_comb begin
    sa = {{W{mul_a[W-1]}}, mul_a};
    sb = {{W{mul_b[W-1]}}, mul_b};
    mul_product = mul_signd ? 64'(sa * sb) : 64'({32'h0, mul_a} * {32'h0, mul_b});
    mul_ready   = rdy_en;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // present a request for one edge, then withdraw it
  task automatic req(input logic [2:0] op, input logic [W-1:0] rs, input logic [W-1:0] rt);
    req_valid = 1'b1; req_op = op; req_rs = rs; req_rt = rt;
    tick();
    req_valid = 1'b0; req_op = 3'b000;
  endtask

  // accept, then wait (bounded) for busy to drop
  task automatic run(input logic [2:0] op, input logic [W-1:0] rs, input logic [W-1:0] rt);
    int n;
    req(op, rs, rt);
    n = 0;
    while (busy && n < 20) begin tick(); n++; end
    if (n >= 20) chk("run_timeout", 1, 0);
  endtask

  initial begin
    nrst = 1'b0; req_valid = 1'b0; req_op = '0; req_rs = '0; req_rt = '0;
    flush = 1'b0; rdy_en = 1'b1;
    tick(); tick();
    nrst = 1'b1;
    tick();

    // 1. reset/idle state
    chk("rst_hilo",  {hi, lo}, 64'h0);
    chk("rst_busy",  busy, 0);
    chk("rst_ready", req_ready, 1);
    chk("rst_start", mul_start, 0);
    chk("rst_ab",    {mul_a, mul_b}, 64'h0);

    // 2. MULT, always-ready: busy exactly 2 cycles, one start pulse
    req(3'b001, 32'hFFFF_FFFE, 32'h0000_0003);
    chk("mult_issue_busy",  busy, 1);
    chk("mult_issue_start", mul_start, 1);
    chk("mult_signd",       mul_signd, 1);
    tick();
    chk("mult_wait_busy",   busy, 1);
    chk("mult_wait_start",  mul_start, 0);
    tick();
    chk("mult_done_busy",   busy, 0);
    chk("mult_hilo",        {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFA);

    // 3. MULTU, same operands
    req(3'b010, 32'hFFFF_FFFE, 32'h0000_0003);
    chk("multu_signd", mul_signd, 0);
    tick(); tick();
    chk("multu_hilo",  {hi, lo}, 64'h0000_0002_FFFF_FFFA);

    // NOP leaves everything
    req(3'b000, 32'h1234, 32'h5678);
    chk("nop_busy", busy, 0);
    chk("nop_hilo", {hi, lo}, 64'h0000_0002_FFFF_FFFA);

    // 4. slow multiplier: ready low 5 cycles after start
    rdy_en = 1'b0;
    req(3'b010, 32'h10, 32'h20);
    tick();
    req_valid = 1'b1; req_op = 3'b011; req_rs = 32'hDEAD;  // offered while busy
    chk("slow_ready_lo", req_ready, 0);
    for (int i = 0; i < 4; i++) tick();
    req_valid = 1'b0; req_op = 3'b000;
    chk("slow_busy",  busy, 1);
    chk("slow_ab",    {mul_a, mul_b}, 64'h0000_0010_0000_0020);
    chk("slow_hilo0", {hi, lo}, 64'h0000_0002_FFFF_FFFA);
    rdy_en = 1'b1;
    tick();
    chk("slow_done",  busy, 0);
    chk("slow_hilo",  {hi, lo}, 64'h0000_0000_0000_0200);
    tick(); tick();                          // ready still high in IDLE
    chk("slow_once",  {hi, lo}, 64'h0000_0000_0000_0200);

    // 5. MTHI/MTLO then flush during WAIT with ready high
    req(3'b011, 32'h11, 32'h0);
    chk("mthi_busy", busy, 0);
    req(3'b100, 32'h22, 32'h0);
    chk("mthi_mtlo", {hi, lo}, 64'h0000_0011_0000_0022);
    rdy_en = 1'b0;
    req(3'b001, 32'h7, 32'h7);
    tick();
    flush = 1'b1; rdy_en = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_busy", busy, 0);
    chk("flush_hilo", {hi, lo}, 64'h0000_0011_0000_0022);
    // flush in ISSUE
    req(3'b001, 32'h7, 32'h7);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    tick();
    chk("flush_iss_busy", busy, 0);
    chk("flush_iss_hilo", {hi, lo}, 64'h0000_0011_0000_0022);
    // flush with MTLO offered in IDLE drops it
    flush = 1'b1;
    req(3'b100, 32'h99, 32'h0);
    flush = 1'b0;
    chk("flush_mtlo", lo, 32'h22);
    run(3'b001, 32'h7, 32'h7);
    chk("post_flush", {hi, lo}, 64'h0000_0000_0000_0031);

    // 6. accumulate ops
    req(3'b100, 32'd10, 32'h0);
    req(3'b011, 32'd0, 32'h0);
    run(3'b101, 32'd4, 32'd5);
`ifdef UPARC_MADD_EN
    chk("madd", {hi, lo}, 64'd30);
    req(3'b100, 32'd0, 32'h0);
    run(3'b111, 32'd1, 32'd1);
    chk("msub", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFF);
`else
    chk("madd_nop", {hi, lo}, 64'd10);
    req(3'b111, 32'd1, 32'd1);
    chk("msub_nop_busy", busy, 0);
`endif

    // reset mid-operation drops everything
    rdy_en = 1'b0;
    req(3'b001, 32'h3, 32'h3);
    tick();
    nrst = 1'b0;
    tick();
    nrst = 1'b1; rdy_en = 1'b1;
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_hilo", {hi, lo}, 64'h0);
    chk("rst_mid_ab",   {mul_a, mul_b}, 64'h0);
    chk("rst_mid_sg",   {mul_start, mul_signd}, 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
